// File: rtl/sync_debounce_pkg.sv
// Shared helpers for the synchronizer/debounce slice: legal parameter
// ranges and the counter width function.
package sync_debounce_pkg;

    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 4;
    localparam int WIDTH_MIN  = 1;
    localparam int WIDTH_MAX  = 32;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Disagreement counter width, never narrower than one bit.
    function automatic int cnt_width(input int filter);
        int w;
        w = clog2(filter + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_debounce_if.sv
// Per-block signal bundle: sample enable and raw inputs in, filtered level
// and edge pulses out. The slave side is the debounce block.
interface sync_debounce_if #(
    parameter int WIDTH = 1
);
    logic             i_ce;
    logic [WIDTH-1:0] i_i;
    logic [WIDTH-1:0] o_o;
    logic [WIDTH-1:0] o_rise;
    logic [WIDTH-1:0] o_fall;
    logic             o_chg;

    modport master (
        output i_ce,
        output i_i,
        input  o_o,
        input  o_rise,
        input  o_fall,
        input  o_chg
    );

    modport slave (
        input  i_ce,
        input  i_i,
        output o_o,
        output o_rise,
        output o_fall,
        output o_chg
    );
endinterface

// File: rtl/sync_filter_bit.sv
// One channel: STAGES-deep synchronizer, optional disagreement filter and
// single-cycle rise/fall detection on the filtered level.
module sync_filter_bit
    import sync_debounce_pkg::*;
#(
    parameter int   STAGES = 2,
    parameter int   FILTER = 0,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ce,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              w_s;
    logic              w_o;
    logic              r_o_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {STAGES{INIT}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign w_s = r_sync[STAGES-1];

    if (FILTER == 0) begin : g_bypass
        // The sample enable only paces the filter; bypass mode ignores it.
        logic w_unused_ce;
        assign w_unused_ce = i_ce;
        assign w_o         = w_s;
    end else begin : g_filter
        localparam int             CW   = cnt_width(FILTER);
        localparam logic [CW-1:0]  LAST = CW'(FILTER - 1);

        logic [CW-1:0] r_cnt;
        logic          r_o;

        // Agreement clears the count at once; the count saturates at LAST
        // because reaching it loads the output and restarts from zero.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
                r_o   <= INIT;
            end else if (w_s == r_o) begin
                r_cnt <= '0;
            end else if (i_ce) begin
                if (r_cnt == LAST) begin
                    r_o   <= w_s;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_o = r_o;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o_d <= INIT;
        end else begin
            r_o_d <= w_o;
        end
    end

    assign o_q    = w_o;
    assign o_rise = w_o & ~r_o_d;
    assign o_fall = ~w_o & r_o_d;

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel synchronizer/debouncer: WIDTH independent sync_filter_bit
// channels plus a combined change flag.
module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int               WIDTH  = 1,
    parameter int               STAGES = 2,
    parameter logic [WIDTH-1:0] INIT   = '0,
    parameter int               FILTER = 0
) (
    input  logic           clk,
    input  logic           rst,
    sync_debounce_if.slave bus
);

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("sync_debounce: STAGES=%0d outside legal range 2..4", STAGES);
    end
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("sync_debounce: WIDTH=%0d outside legal range 1..32", WIDTH);
    end
    if (FILTER < 0) begin : g_bad_filter
        $error("sync_debounce: FILTER=%0d must not be negative", FILTER);
    end

    logic [WIDTH-1:0] w_o;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        sync_filter_bit #(
            .STAGES (STAGES),
            .FILTER (FILTER),
            .INIT   (INIT[g])
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .i_ce   (bus.i_ce),
            .i_d    (bus.i_i[g]),
            .o_q    (w_o[g]),
            .o_rise (w_rise[g]),
            .o_fall (w_fall[g])
        );
    end

    assign bus.o_o    = w_o;
    assign bus.o_rise = w_rise;
    assign bus.o_fall = w_fall;
    assign bus.o_chg  = |(w_rise | w_fall);

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce: four configurations driven in one
// linear sequence, every expectation written out by hand.
module tb_sync_debounce;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // u0: plain 2-flop sync; u1: STAGES=3 FILTER=4; u2: 8-bit INIT=A5 FILTER=2;
    // u3: FILTER=8 for reset-mid-count.
    sync_debounce_if #(.WIDTH(1)) if0 ();
    sync_debounce_if #(.WIDTH(1)) if1 ();
    sync_debounce_if #(.WIDTH(8)) if2 ();
    sync_debounce_if #(.WIDTH(1)) if3 ();

    sync_debounce #(.WIDTH(1), .STAGES(2), .INIT(1'b0), .FILTER(0))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    sync_debounce #(.WIDTH(1), .STAGES(3), .INIT(1'b0), .FILTER(4))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    sync_debounce #(.WIDTH(8), .STAGES(2), .INIT(8'hA5), .FILTER(2))
        u2 (.clk(clk), .rst(rst), .bus(if2));
    sync_debounce #(.WIDTH(1), .STAGES(2), .INIT(1'b0), .FILTER(8))
        u3 (.clk(clk), .rst(rst), .bus(if3));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int samples;

        rst = 1'b1;
        if0.i_ce = 1'b1; if0.i_i = 1'b0;
        if1.i_ce = 1'b1; if1.i_i = 1'b0;
        if2.i_ce = 1'b1; if2.i_i = 8'hA5;
        if3.i_ce = 1'b1; if3.i_i = 1'b0;

        // Reset state
        #1;
        chk("rst_u0_o",    32'(if0.o_o),    32'h0);
        chk("rst_u0_chg",  32'(if0.o_chg),  32'h0);
        chk("rst_u2_o",    32'(if2.o_o),    32'hA5);
        chk("rst_u2_rise", 32'(if2.o_rise), 32'h0);
        chk("rst_u2_fall", 32'(if2.o_fall), 32'h0);
        chk("rst_u2_chg",  32'(if2.o_chg),  32'h0);
        for (int k = 0; k < 3; k++) step();
        rst = 1'b0;

        // Release with i == INIT: no pulses
        for (int n = 1; n <= 3; n++) begin
            step();
            chk("rel_u2_o",    32'(if2.o_o),    32'hA5);
            chk("rel_u2_rise", 32'(if2.o_rise), 32'h0);
            chk("rel_u2_fall", 32'(if2.o_fall), 32'h0);
            chk("rel_u2_chg",  32'(if2.o_chg),  32'h0);
        end

        // Bypass mode, 2 stages: o follows after 2 edges, single rise pulse
        if0.i_i = 1'b1;
        step();
        chk("a_o_e1",    32'(if0.o_o),    32'h0);
        chk("a_rise_e1", 32'(if0.o_rise), 32'h0);
        step();
        chk("a_o_e2",    32'(if0.o_o),    32'h1);
        chk("a_rise_e2", 32'(if0.o_rise), 32'h1);
        chk("a_chg_e2",  32'(if0.o_chg),  32'h1);
        step();
        chk("a_o_e3",    32'(if0.o_o),    32'h1);
        chk("a_rise_e3", 32'(if0.o_rise), 32'h0);
        chk("a_chg_e3",  32'(if0.o_chg),  32'h0);

        // STAGES=3 FILTER=4 ce=1: o reaches 1 exactly at edge 7
        if1.i_i = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            chk("b_o",    32'(if1.o_o),    (n >= 7) ? 32'h1 : 32'h0);
            chk("b_rise", 32'(if1.o_rise), (n == 7) ? 32'h1 : 32'h0);
        end
        if1.i_i = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            step();
            chk("b_o_fall", 32'(if1.o_o),    (n >= 7) ? 32'h0 : 32'h1);
            chk("b_fall",   32'(if1.o_fall), (n == 7) ? 32'h1 : 32'h0);
        end

        // 3-cycle glitch is rejected
        if1.i_i = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            if (n == 4) if1.i_i = 1'b0;
            step();
            chk("g_o",    32'(if1.o_o),    32'h0);
            chk("g_rise", 32'(if1.o_rise), 32'h0);
            chk("g_fall", 32'(if1.o_fall), 32'h0);
        end

        // ce held low: output never moves
        if1.i_ce = 1'b0;
        if1.i_i  = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            step();
            chk("c_noce_o", 32'(if1.o_o), 32'h0);
        end

        // ce every 3rd cycle: the 4th sample (c == 11) loads o
        samples = 0;
        for (int c = 0; c < 15; c++) begin
            if1.i_ce = (c % 3 == 2);
            step();
            chk("c_ce_o",    32'(if1.o_o),    (c >= 11) ? 32'h1 : 32'h0);
            chk("c_ce_rise", 32'(if1.o_rise), (c == 11) ? 32'h1 : 32'h0);
        end
        if1.i_ce = 1'b1;

        // 8-bit simultaneous change A5 -> 5A, latency 2 + 2
        if2.i_i = 8'h5A;
        for (int n = 1; n <= 5; n++) begin
            step();
            chk("d_o",    32'(if2.o_o),    (n >= 4) ? 32'h5A : 32'hA5);
            chk("d_rise", 32'(if2.o_rise), (n == 4) ? 32'h5A : 32'h00);
            chk("d_fall", 32'(if2.o_fall), (n == 4) ? 32'hA5 : 32'h00);
            chk("d_chg",  32'(if2.o_chg),  (n == 4) ? 32'h1  : 32'h0);
        end

        // FILTER=8: full change takes 2 + 8 edges
        if3.i_i = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            chk("e_o",    32'(if3.o_o),    (n >= 10) ? 32'h1 : 32'h0);
            chk("e_rise", 32'(if3.o_rise), (n == 10) ? 32'h1 : 32'h0);
        end

        // Asynchronous reset forces o back to INIT without an edge pulse
        #2 rst = 1'b1;
        #1;
        chk("e_arst_o",    32'(if3.o_o),    32'h0);
        chk("e_arst_rise", 32'(if3.o_rise), 32'h0);
        chk("e_arst_fall", 32'(if3.o_fall), 32'h0);
        chk("e_arst_u0_o", 32'(if0.o_o),    32'h0);
        #1 rst = 1'b0;

        // Count up to 5, reset mid-count, then a full 2 + 8 is needed again
        for (int n = 1; n <= 7; n++) begin
            step();
            chk("e_pre_o", 32'(if3.o_o), 32'h0);
        end
        #2 rst = 1'b1;
        #1;
        chk("e_mid_o", 32'(if3.o_o), 32'h0);
        #1 rst = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            step();
            chk("e_post_o",    32'(if3.o_o),    (n >= 10) ? 32'h1 : 32'h0);
            chk("e_post_rise", 32'(if3.o_rise), (n == 10) ? 32'h1 : 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
